frv_intc: RTL and testbench

External interrupt controller that sits outside the core and drives the core's external and NMI interrupt-pending inputs.
- Gathers up to 15 external interrupt lines plus one NMI line.
- Latches and prioritises requests, presents them as ex_pending/ex_cause and nmi_pending.
- Software services them through a claim/complete register interface on the peripheral bus.

---
 rtl/frv_intc.sv | 233 +++++++++++++++++++++++
 tb/tb_frv_intc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_intc.sv
// ---------------------------------------------------------------------------
// frv_intc - external interrupt controller
//
// This block sits outside the core. It drives the core's external-interrupt
// and NMI pending inputs. It collects up to NSRC external lines plus one NMI
// line, latches and prioritises them, and lets software service them through
// a claim/complete register interface.
//
// Parameters
//   NSRC        number of external sources (1..15); source i has ID i+1
//
// Ports
//   g_clk       clock
//   g_resetn    synchronous, active-low reset
//   irq_src     external interrupt lines, active high, already synchronised
//   nmi_src     non-maskable interrupt line, active high, synchronised
//   reg_req     register access request (single cycle)
//   reg_wen     1 = write, 0 = read
//   reg_addr    word index
//                 0 ENABLE
//                 1 PENDING
//                 2 CLAIM/COMPLETE
//                 3 NMI
//                 4 INSERVICE
//                 5 TRIGGER
//                 6-7 reserved
//   reg_wdata   write data
//   reg_ack     access done, one cycle after reg_req
//   reg_rdata   read data, valid with reg_ack, zero otherwise
//   ex_pending  an enabled external interrupt is pending
//   ex_cause    ID of the highest-priority enabled pending source, 0 if none
//   nmi_pending NMI latched and not yet cleared by software
//
// Build option
//   FRV_INTC_EDGE_EN  adds the TRIGGER register and per-source edge mode.
//                     When it is not defined, every source is level mode,
//                     address 5 reads 0, and no edge-detect flops exist.
// ---------------------------------------------------------------------------
module frv_intc #(
    parameter int NSRC = 15
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [NSRC-1:0] irq_src,
    input  logic            nmi_src,
    input  logic            reg_req,
    input  logic            reg_wen,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic            reg_ack,
    output logic [31:0]     reg_rdata,
    output logic            ex_pending,
    output logic [3:0]      ex_cause,
    output logic            nmi_pending
);

    localparam logic [2:0] ADDR_ENABLE    = 3'd0;
    localparam logic [2:0] ADDR_PENDING   = 3'd1;
    localparam logic [2:0] ADDR_CLAIM     = 3'd2;
    localparam logic [2:0] ADDR_NMI       = 3'd3;
    localparam logic [2:0] ADDR_INSERVICE = 3'd4;
    localparam logic [2:0] ADDR_TRIGGER   = 3'd5;

    logic [NSRC-1:0] enable_q,    enable_d;
    logic [NSRC-1:0] pending_q,   pending_d;
    logic [NSRC-1:0] inservice_q, inservice_d;
    logic            nmi_latch_q, nmi_latch_d;
    logic            nmi_prev_q,  nmi_prev_d;
    logic            reg_ack_q,   reg_ack_d;
    logic [31:0]     reg_rdata_q, reg_rdata_d;
    logic            ex_pending_q, ex_pending_d;
    logic [3:0]      ex_cause_q,  ex_cause_d;
    logic            nmi_pending_q, nmi_pending_d;

    logic            rd_en;
    logic            wr_en;
    logic            claim_en;
    logic            complete_en;
    logic            nmi_clear;
    logic            nmi_edge;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] gw_set;
    logic [NSRC-1:0] trigger_rd;
    logic            win_valid;
    logic [3:0]      win_idx;
    logic [3:0]      win_id;

    // Only some write-data bits are meaningful. This reduction keeps the rest
    // visibly consumed.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

    assign rd_en       = reg_req & ~reg_wen;
    assign wr_en       = reg_req &  reg_wen;
    assign claim_en    = rd_en & (reg_addr == ADDR_CLAIM);
    assign complete_en = wr_en & (reg_addr == ADDR_CLAIM);
    assign nmi_clear   = wr_en & (reg_addr == ADDR_NMI) & reg_wdata[0];
    assign nmi_edge    = nmi_src & ~nmi_prev_q;

    // A source that is in service cannot be claimed again until software
    // completes it. In level mode, pending and inservice are never both set,
    // so this mask matters only for a queued edge.
    assign eligible = pending_q & enable_q & ~inservice_q;

`ifdef FRV_INTC_EDGE_EN
    logic [NSRC-1:0] trigger_q, trigger_d;
    logic [NSRC-1:0] irq_prev_q, irq_prev_d;

    // An edge-mode source sets pending on a rising edge even while it is in
    // service. This queues one edge. Further edges merge into it.
    always_comb begin
        trigger_d  = trigger_q;
        irq_prev_d = irq_src;
        if (wr_en && (reg_addr == ADDR_TRIGGER)) begin
            trigger_d = reg_wdata[NSRC-1:0];
        end
        for (int i = 0; i < NSRC; i++) begin
            if (trigger_q[i]) begin
                gw_set[i] = irq_src[i] & ~irq_prev_q[i];
            end else begin
                gw_set[i] = irq_src[i] & ~inservice_q[i];
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            trigger_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            trigger_q  <= trigger_d;
            irq_prev_q <= irq_prev_d;
        end
    end

    assign trigger_rd = trigger_q;
`else
    assign gw_set     = irq_src & ~inservice_q;
    assign trigger_rd = '0;
`endif

    // Fixed priority: the lowest index wins. The loop runs downwards so the
    // last assignment is the lowest eligible index.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_idx   = 4'(i);
            end
        end
        win_id = win_valid ? (win_idx + 4'd1) : 4'd0;
    end

    always_comb begin
        enable_d      = enable_q;
        pending_d     = pending_q | gw_set;
        inservice_d   = inservice_q;
        nmi_prev_d    = nmi_src;
        nmi_latch_d   = (nmi_latch_q & ~nmi_clear) | nmi_edge;
        reg_ack_d     = reg_req;
        reg_rdata_d   = 32'd0;
        ex_pending_d  = |eligible;
        ex_cause_d    = win_id;
        nmi_pending_d = nmi_latch_q;

        if (wr_en && (reg_addr == ADDR_ENABLE)) begin
            enable_d = reg_wdata[NSRC-1:0];
        end

        // Matching the ID against i+1 also rejects ID 0 and IDs above NSRC.
        for (int i = 0; i < NSRC; i++) begin
            if (complete_en && (reg_wdata[3:0] == 4'(i + 1)) && inservice_q[i]) begin
                inservice_d[i] = 1'b0;
            end
        end

        // The claim is applied after the gateway set, so a claim wins if both
        // hit the same source in the same cycle.
        for (int i = 0; i < NSRC; i++) begin
            if (claim_en && win_valid && (win_idx == 4'(i))) begin
                pending_d[i]   = 1'b0;
                inservice_d[i] = 1'b1;
            end
        end

        if (rd_en) begin
            case (reg_addr)
                ADDR_ENABLE:    reg_rdata_d = {{(32 - NSRC){1'b0}}, enable_q};
                ADDR_PENDING:   reg_rdata_d = {{(32 - NSRC){1'b0}}, pending_q};
                ADDR_CLAIM:     reg_rdata_d = {28'd0, win_id};
                ADDR_NMI:       reg_rdata_d = {31'd0, nmi_latch_q};
                ADDR_INSERVICE: reg_rdata_d = {{(32 - NSRC){1'b0}}, inservice_q};
                ADDR_TRIGGER:   reg_rdata_d = {{(32 - NSRC){1'b0}}, trigger_rd};
                default:        reg_rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            enable_q      <= '0;
            pending_q     <= '0;
            inservice_q   <= '0;
            nmi_latch_q   <= 1'b0;
            nmi_prev_q    <= 1'b0;
            reg_ack_q     <= 1'b0;
            reg_rdata_q   <= 32'd0;
            ex_pending_q  <= 1'b0;
            ex_cause_q    <= 4'd0;
            nmi_pending_q <= 1'b0;
        end else begin
            enable_q      <= enable_d;
            pending_q     <= pending_d;
            inservice_q   <= inservice_d;
            nmi_latch_q   <= nmi_latch_d;
            nmi_prev_q    <= nmi_prev_d;
            reg_ack_q     <= reg_ack_d;
            reg_rdata_q   <= reg_rdata_d;
            ex_pending_q  <= ex_pending_d;
            ex_cause_q    <= ex_cause_d;
            nmi_pending_q <= nmi_pending_d;
        end
    end

    assign reg_ack     = reg_ack_q;
    assign reg_rdata   = reg_rdata_q;
    assign ex_pending  = ex_pending_q;
    assign ex_cause    = ex_cause_q;
    assign nmi_pending = nmi_pending_q;

endmodule

// File: tb/tb_frv_intc.sv
// ---------------------------------------------------------------------------
// tb_frv_intc - self-checking bench for frv_intc (NSRC = 15)
//
// Every register access pushes its expected read data onto a scoreboard
// queue. The monitor pops one entry for each reg_ack. Core-facing outputs
// are checked directly, one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_frv_intc;

    localparam int NSRC = 15;

`ifdef FRV_INTC_EDGE_EN
    localparam logic [31:0] TRIG_READBACK = 32'h0000_0002;
`else
    localparam logic [31:0] TRIG_READBACK = 32'h0000_0000;
`endif

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic            nmi_src = 1'b0;
    logic            reg_req = 1'b0;
    logic            reg_wen = 1'b0;
    logic [2:0]      reg_addr = 3'd0;
    logic [31:0]     reg_wdata = 32'd0;
    logic            reg_ack;
    logic [31:0]     reg_rdata;
    logic            ex_pending;
    logic [3:0]      ex_cause;
    logic            nmi_pending;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic        wen;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[24];

    frv_intc #(.NSRC(NSRC)) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .irq_src     (irq_src),
        .nmi_src     (nmi_src),
        .reg_req     (reg_req),
        .reg_wen     (reg_wen),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_ack     (reg_ack),
        .reg_rdata   (reg_rdata),
        .ex_pending  (ex_pending),
        .ex_cause    (ex_cause),
        .nmi_pending (nmi_pending)
    );

    always #5 g_clk = ~g_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Drive one register access for a single cycle and queue its expected data.
    task automatic applyStimulus(input logic wen, input logic [2:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input string name);
        reg_req   = 1'b1;
        reg_wen   = wen;
        reg_addr  = addr;
        reg_wdata = wdata;
        exp_q.push_back(exp_rdata);
        name_q.push_back(name);
        tick();
        reg_req   = 1'b0;
        reg_wen   = 1'b0;
        reg_addr  = 3'd0;
        reg_wdata = 32'd0;
    endtask

    // Scoreboard side: each ack consumes one expected entry. Outside an ack,
    // read data must be zero.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (reg_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL ack_without_request: actual=ack required=no_ack");
                end else begin
                    logic [31:0] e;
                    string       n;
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    checkOutput(n, reg_rdata, e);
                end
            end else begin
                checkOutput("rdata_idle", reg_rdata, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;

        // Register-map vectors, applied back to back right after reset.
        vecs[0]  = '{1'b0, 3'd0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 3'd1, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 3'd2, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'd3, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 3'd5, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 3'd6, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 3'd7, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 3'd0, 32'h0, 32'h0000_7FFF};
        vecs[10] = '{1'b1, 3'd0, 32'h0000_1234, 32'h0};
        vecs[11] = '{1'b0, 3'd0, 32'h0, 32'h0000_1234};
        vecs[12] = '{1'b1, 3'd0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0};
        vecs[14] = '{1'b0, 3'd1, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 32'h0};
        vecs[16] = '{1'b0, 3'd4, 32'h0, 32'h0};
        vecs[17] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0};
        vecs[18] = '{1'b0, 3'd6, 32'h0, 32'h0};
        vecs[19] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0};
        vecs[20] = '{1'b0, 3'd7, 32'h0, 32'h0};
        vecs[21] = '{1'b1, 3'd5, 32'h0000_0002, 32'h0};
        vecs[22] = '{1'b0, 3'd5, 32'h0, TRIG_READBACK};
        vecs[23] = '{1'b1, 3'd5, 32'h0, 32'h0};

        $display("[TB] reset");
        g_resetn = 1'b0;
        repeat (3) tick();
        g_resetn = 1'b1;
        tick();
        checkOutput("reset_reg_ack", 32'(reg_ack), 32'd0);
        checkOutput("reset_reg_rdata", reg_rdata, 32'd0);
        checkOutput("reset_ex_pending", 32'(ex_pending), 32'd0);
        checkOutput("reset_ex_cause", 32'(ex_cause), 32'd0);
        checkOutput("reset_nmi_pending", 32'(nmi_pending), 32'd0);

        $display("[TB] register map vectors");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                          $sformatf("vec%0d", i));
        end
        tick();
        checkOutput("vec_ex_pending", 32'(ex_pending), 32'd0);

        // Latency and priority of the core-facing outputs.
        $display("[TB] priority and claim");
        applyStimulus(1'b1, 3'd0, 32'h0000_0005, 32'h0, "wr_enable_5");
        irq_src[2] = 1'b1;
        tick();
        checkOutput("lat_n1_ex_pending", 32'(ex_pending), 32'd0);
        tick();
        checkOutput("lat_n2_ex_pending", 32'(ex_pending), 32'd1);
        checkOutput("lat_n2_ex_cause", 32'(ex_cause), 32'd3);
        irq_src[0] = 1'b1;
        tick();
        tick();
        checkOutput("prio_ex_cause_1", 32'(ex_cause), 32'd1);
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd1, "claim_src1");
        checkOutput("claim_n1_ex_cause", 32'(ex_cause), 32'd1);
        tick();
        checkOutput("claim_n2_ex_cause", 32'(ex_cause), 32'd3);

        // Level line still high while in service: pending stays clear.
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0000_0004, "pending_after_claim");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0000_0001, "inservice_after_claim");
        applyStimulus(1'b1, 3'd2, 32'd9, 32'h0, "complete_id9");
        applyStimulus(1'b1, 3'd2, 32'd0, 32'h0, "complete_id0");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0000_0001, "inservice_bad_ids");
        applyStimulus(1'b1, 3'd2, 32'd1, 32'h0, "complete_id1");
        tick();
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0000_0005, "pending_reset_after_complete");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0000_0000, "inservice_after_complete");
        applyStimulus(1'b1, 3'd2, 32'd0, 32'h0, "complete_id0_idle");
        applyStimulus(1'b1, 3'd2, 32'd9, 32'h0, "complete_id9_idle");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0000_0000, "inservice_idle_bad_ids");

        // Pending is held after the lines drop, until it is claimed.
        irq_src = '0;
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd1, "drain_claim1");
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd3, "drain_claim3");
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd0, "drain_claim_none");
        applyStimulus(1'b1, 3'd2, 32'd1, 32'h0, "drain_complete1");
        applyStimulus(1'b1, 3'd2, 32'd3, 32'h0, "drain_complete3");
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0, "drain_pending");
        tick();
        tick();
        checkOutput("drain_ex_pending", 32'(ex_pending), 32'd0);
        checkOutput("drain_ex_cause", 32'(ex_cause), 32'd0);

        // A disabled source is pending but invisible to the core and to claim.
        $display("[TB] masked source");
        irq_src[4] = 1'b1;
        tick();
        tick();
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0000_0010, "masked_pending");
        checkOutput("masked_ex_pending", 32'(ex_pending), 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd0, "masked_claim");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0, "masked_inservice");
        applyStimulus(1'b1, 3'd0, 32'h0000_0015, 32'h0, "wr_enable_15");
        found = 1'b0;
        for (int c = 0; c < 3 && !found; c++) begin
            tick();
            if (ex_pending) found = 1'b1;
        end
        checkOutput("enable_ex_pending", 32'(ex_pending), 32'd1);
        checkOutput("enable_ex_cause", 32'(ex_cause), 32'd5);
        irq_src[4] = 1'b0;
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd5, "claim_src5");
        applyStimulus(1'b1, 3'd2, 32'd5, 32'h0, "complete_src5");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0, "inservice_src5_done");

        // NMI edge latch, same-cycle clear and edge, then a plain clear.
        $display("[TB] nmi");
        nmi_src = 1'b1;
        tick();
        nmi_src = 1'b0;
        checkOutput("nmi_n1", 32'(nmi_pending), 32'd0);
        tick();
        checkOutput("nmi_n2", 32'(nmi_pending), 32'd1);
        tick();
        tick();
        checkOutput("nmi_held", 32'(nmi_pending), 32'd1);
        applyStimulus(1'b0, 3'd3, 32'h0, 32'd1, "nmi_read_set");
        nmi_src = 1'b1;
        applyStimulus(1'b1, 3'd3, 32'd1, 32'h0, "nmi_clear_with_edge");
        nmi_src = 1'b0;
        tick();
        tick();
        checkOutput("nmi_clear_edge_kept", 32'(nmi_pending), 32'd1);
        applyStimulus(1'b0, 3'd3, 32'h0, 32'd1, "nmi_read_kept");
        applyStimulus(1'b1, 3'd3, 32'd1, 32'h0, "nmi_clear");
        tick();
        checkOutput("nmi_cleared", 32'(nmi_pending), 32'd0);
        applyStimulus(1'b0, 3'd3, 32'h0, 32'd0, "nmi_read_cleared");

`ifdef FRV_INTC_EDGE_EN
        // Edge mode queues one edge while in service and blocks a second claim.
        $display("[TB] edge mode");
        applyStimulus(1'b1, 3'd5, 32'h0000_0002, 32'h0, "wr_trigger_2");
        applyStimulus(1'b1, 3'd0, 32'h0000_0002, 32'h0, "wr_enable_2");
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        tick();
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0000_0002, "edge_pending");
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd2, "edge_claim2");
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        tick();
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0000_0002, "edge_queued_pending");
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd0, "edge_claim_blocked");
        applyStimulus(1'b0, 3'd4, 32'h0, 32'h0000_0002, "edge_inservice");
        applyStimulus(1'b1, 3'd2, 32'd2, 32'h0, "edge_complete2");
        applyStimulus(1'b0, 3'd2, 32'h0, 32'd2, "edge_claim_queued");
        applyStimulus(1'b1, 3'd2, 32'd2, 32'h0, "edge_complete2b");
        applyStimulus(1'b0, 3'd1, 32'h0, 32'h0, "edge_pending_empty");
`endif

        tick();
        tick();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
